// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch stage: PC, fetch handshake, IR and field decode
module busca_instrucao #(
    parameter int LARGURA_PC     = 8,
    parameter int PC_INICIAL     = 0,
    parameter int TIMEOUT_ESPERA = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [LARGURA_PC-1:0] mem_end,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_dado,
    input  logic                  EscPC,
    input  logic                  Ji,
    input  logic                  Beqz,
    input  logic                  Zero,
    input  logic                  STOP,
    output logic [2:0]            opcode,
    output logic [1:0]            BitVerificacao,
    output logic [1:0]            reg_a,
    output logic [1:0]            reg_b,
    output logic [4:0]            imediato,
    output logic                  instr_valida,
    output logic [LARGURA_PC-1:0] pc,
    output logic                  parado,
    output logic                  erro_busca
);

    localparam int LARGURA_CNT = $clog2(TIMEOUT_ESPERA + 1);

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        EXECUTA,
        PARADO
    } estado_t;

    estado_t                estado;
    logic [7:0]             ir;
    logic [LARGURA_CNT-1:0] cnt_espera;
    logic [LARGURA_PC-1:0]  alvo_salto;

    // Fields overlap on purpose; Controle picks the ones that apply to each opcode
    assign opcode         = ir[7:5];
    assign reg_a          = ir[4:3];
    assign reg_b          = ir[2:1];
    assign BitVerificacao = ir[1:0];
    assign imediato       = ir[4:0];
    assign alvo_salto     = LARGURA_PC'(ir[4:0]);
    assign mem_end        = pc;

    // Fetch/execute sequencer; every output is registered so reset clears them at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            pc           <= LARGURA_PC'(PC_INICIAL);
            ir           <= '0;
            cnt_espera   <= '0;
            mem_req      <= 1'b0;
            instr_valida <= 1'b0;
            parado       <= 1'b0;
            erro_busca   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    estado  <= BUSCA;
                    mem_req <= 1'b1;
                end
                BUSCA: begin
                    if (mem_ack) begin
                        ir           <= mem_dado;
                        cnt_espera   <= '0;
                        mem_req      <= 1'b0;
                        instr_valida <= 1'b1;
                        estado       <= EXECUTA;
                    end else if (cnt_espera == LARGURA_CNT'(TIMEOUT_ESPERA - 1)) begin
                        // This is the TIMEOUT_ESPERA-th unanswered cycle: give up for good
                        erro_busca <= 1'b1;
                        parado     <= 1'b1;
                        mem_req    <= 1'b0;
                        estado     <= PARADO;
                    end else begin
                        cnt_espera <= cnt_espera + LARGURA_CNT'(1);
                    end
                end
                EXECUTA: begin
                    if (STOP) begin
                        instr_valida <= 1'b0;
                        parado       <= 1'b1;
                        estado       <= PARADO;
                    end else if (EscPC) begin
                        instr_valida <= 1'b0;
                        mem_req      <= 1'b1;
                        estado       <= BUSCA;
                        if (Ji || (Beqz && Zero)) begin
                            pc <= alvo_salto;
                        end else begin
                            pc <= pc + LARGURA_PC'(1);
                        end
                    end
                end
                PARADO: begin
                    estado <= PARADO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - scoreboard bench for busca_instrucao
module tb_busca_instrucao;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       mem_req;
    logic [7:0] mem_end;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_dado = 8'h00;
    logic       EscPC = 1'b0;
    logic       Ji = 1'b0;
    logic       Beqz = 1'b0;
    logic       Zero = 1'b0;
    logic       STOP = 1'b0;
    logic [2:0] opcode;
    logic [1:0] BitVerificacao;
    logic [1:0] reg_a;
    logic [1:0] reg_b;
    logic [4:0] imediato;
    logic       instr_valida;
    logic [7:0] pc;
    logic       parado;
    logic       erro_busca;

    int checks = 0;
    int failures = 0;
    logic [7:0] fila[$];
    logic [7:0] esperado_mon;

    busca_instrucao #(
        .LARGURA_PC    (8),
        .PC_INICIAL    (0),
        .TIMEOUT_ESPERA(15)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_end       (mem_end),
        .mem_ack       (mem_ack),
        .mem_dado      (mem_dado),
        .EscPC         (EscPC),
        .Ji            (Ji),
        .Beqz          (Beqz),
        .Zero          (Zero),
        .STOP          (STOP),
        .opcode        (opcode),
        .BitVerificacao(BitVerificacao),
        .reg_a         (reg_a),
        .reg_b         (reg_b),
        .imediato      (imediato),
        .instr_valida  (instr_valida),
        .pc            (pc),
        .parado        (parado),
        .erro_busca    (erro_busca)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nome, atual, esperado);
        end
    endtask

    // Monitor: every acknowledged fetch must present the next queued address
    always @(negedge clock) begin
        if (reset && mem_req && mem_ack) begin
            if (fila.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor_fila actual=empty expected=entry mem_end=%0h", mem_end);
            end else begin
                esperado_mon = fila.pop_front();
                chk("monitor_mem_end", {24'h0, mem_end}, {24'h0, esperado_mon});
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("wait_req", {31'h0, mem_req}, 32'h1);
    endtask

    task automatic fetch(input int waits, input logic [7:0] d, input logic [7:0] addr);
        fila.push_back(addr);
        wait_req();
        chk("mem_end_busca", {24'h0, mem_end}, {24'h0, addr});
        repeat (waits) begin
            @(negedge clock);
            chk("req_espera", {31'h0, mem_req}, 32'h1);
            chk("valida_espera", {31'h0, instr_valida}, 32'h0);
            @(posedge clock);
            #1;
        end
        mem_ack  = 1'b1;
        mem_dado = d;
        @(posedge clock);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic exec(input int hold, input logic esc, input logic ji, input logic bq,
                        input logic z, input logic st);
        repeat (hold) begin
            @(negedge clock);
            chk("valida_hold", {31'h0, instr_valida}, 32'h1);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        chk("valida_exec", {31'h0, instr_valida}, 32'h1);
        EscPC = esc;
        Ji    = ji;
        Beqz  = bq;
        Zero  = z;
        STOP  = st;
        @(posedge clock);
        #1;
        EscPC = 1'b0;
        Ji    = 1'b0;
        Beqz  = 1'b0;
        Zero  = 1'b0;
        STOP  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clock);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_valida", {31'h0, instr_valida}, 32'h0);
        chk("rst_parado", {31'h0, parado}, 32'h0);
        chk("rst_erro", {31'h0, erro_busca}, 32'h0);
        chk("rst_pc", {24'h0, pc}, 32'h0);
        chk("rst_opcode", {29'h0, opcode}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("ocioso_req", {31'h0, mem_req}, 32'h0);
        @(posedge clock);
        #1;

        // Sequential fetch with two wait cycles, held in EXECUTA, then pc+1
        fetch(2, 8'h0A, 8'd0);
        chk("f1_opcode", {29'h0, opcode}, 32'h0);
        chk("f1_reg_a", {30'h0, reg_a}, 32'h1);
        chk("f1_reg_b", {30'h0, reg_b}, 32'h1);
        chk("f1_bitv", {30'h0, BitVerificacao}, 32'h2);
        chk("f1_imediato", {27'h0, imediato}, 32'h0A);
        chk("f1_req_exec", {31'h0, mem_req}, 32'h0);
        exec(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("seq_pc", {24'h0, pc}, 32'd1);
        chk("seq_mem_end", {24'h0, mem_end}, 32'd1);
        chk("seq_valida_baixa", {31'h0, instr_valida}, 32'h0);

        // Unconditional jump
        fetch(0, 8'b011_10110, 8'd1);
        chk("ji_opcode", {29'h0, opcode}, 32'h3);
        exec(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ji_pc", {24'h0, pc}, 32'd22);

        // Branch taken, then branch not taken
        fetch(1, 8'b100_00011, 8'd22);
        exec(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("beqz_taken_pc", {24'h0, pc}, 32'd3);
        fetch(0, 8'b100_00011, 8'd3);
        exec(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("beqz_not_taken_pc", {24'h0, pc}, 32'd4);

        // Wrap-around: jump to 31, step up to 255, then one more step
        fetch(0, 8'b011_11111, 8'd4);
        exec(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("salto31_pc", {24'h0, pc}, 32'd31);
        for (int i = 31; i < 255; i++) begin
            fetch(0, 8'h20, 8'(i));
            exec(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("pc_255", {24'h0, pc}, 32'd255);
        fetch(0, 8'h20, 8'd255);
        exec(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", {24'h0, pc}, 32'd0);
        chk("wrap_mem_end", {24'h0, mem_end}, 32'd0);

        // STOP wins over EscPC and Ji; later inputs are ignored
        fetch(0, 8'b111_00101, 8'd0);
        exec(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("stop_pc", {24'h0, pc}, 32'd0);
        chk("stop_parado", {31'h0, parado}, 32'h1);
        chk("stop_valida", {31'h0, instr_valida}, 32'h0);
        chk("stop_req", {31'h0, mem_req}, 32'h0);
        mem_ack = 1'b1;
        EscPC   = 1'b1;
        Ji      = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        mem_ack = 1'b0;
        EscPC   = 1'b0;
        Ji      = 1'b0;
        chk("parado_pc", {24'h0, pc}, 32'd0);
        chk("parado_hold", {31'h0, parado}, 32'h1);
        chk("parado_req", {31'h0, mem_req}, 32'h0);
        chk("parado_valida", {31'h0, instr_valida}, 32'h0);

        // Fetch timeout: 14 unanswered cycles are tolerated, the 15th halts
        reset = 1'b0;
        #1;
        chk("rst2_parado", {31'h0, parado}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_req();
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        chk("timeout_antes_erro", {31'h0, erro_busca}, 32'h0);
        chk("timeout_antes_req", {31'h0, mem_req}, 32'h1);
        @(posedge clock);
        #1;
        chk("timeout_erro", {31'h0, erro_busca}, 32'h1);
        chk("timeout_parado", {31'h0, parado}, 32'h1);
        chk("timeout_req", {31'h0, mem_req}, 32'h0);

        // Reset mid-fetch drops mem_req without a clock edge
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst3_erro", {31'h0, erro_busca}, 32'h0);
        reset = 1'b1;
        wait_req();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async_req", {31'h0, mem_req}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ocioso_req", {31'h0, mem_req}, 32'h0);
        @(posedge clock);
        #1;
        chk("rst_busca_req", {31'h0, mem_req}, 32'h1);
        chk("rst_busca_end", {24'h0, mem_end}, 32'd0);
        fetch(0, 8'h41, 8'd0);
        chk("rst_fetch_opcode", {29'h0, opcode}, 32'h2);
        chk("rst_fetch_valida", {31'h0, instr_valida}, 32'h1);

        @(negedge clock);
        chk("fila_vazia", fila.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction-fetch stage sitting directly upstream of Controle and the register/ULA datapath of the 8-bit processor. Holds the PC and fetches one 8-bit instruction per cycle of operation through a req/ack handshake with instruction memory. Latches the instruction, presents the decoded fields (opcode, BitVerificacao, register and immediate fields) to Controle, then updates the PC from Controle's EscPC/Ji/Beqz and the ULA's Zero flag. Enters a permanent halt on STOP or on a fetch timeout.

Parameters:
LARGURA_PC, 8, PC and memory address width in bits.
PC_INICIAL, 0, PC value loaded on reset.
TIMEOUT_ESPERA, 15, maximum number of cycles to wait for mem_ack before declaring a fetch error.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
mem_req  output  1  fetch request to instruction memory.
mem_end  output  LARGURA_PC  fetch address; always equal to pc.
mem_ack  input  1  memory has mem_dado valid in this cycle.
mem_dado  input  8  instruction word from memory.
EscPC  input  1  from Controle: commit the PC update now.
Ji  input  1  from Controle: unconditional jump.
Beqz  input  1  from Controle: branch if Zero.
Zero  input  1  from ULA.
STOP  input  1  from Controle: halt.
opcode  output  3  instr[7:5].
BitVerificacao  output  2  instr[1:0].
reg_a  output  2  instr[4:3].
reg_b  output  2  instr[2:1].
imediato  output  5  instr[4:0]; zero-extended to LARGURA_PC when used as a jump target.
instr_valida  output  1  the decoded fields are valid.
pc  output  LARGURA_PC  current PC.
parado  output  1  the processor is halted.
erro_busca  output  1  the fetch timed out; sticky.

Behaviour:
- Fields overlap by design; Controle selects which fields apply per opcode. All field outputs come straight from the registered instruction register (IR).
- Reset (asserted asynchronously):
  - pc = PC_INICIAL, IR = 0, state = OCIOSO, timeout counter = 0.
  - mem_req = 0, instr_valida = 0, parado = 0, erro_busca = 0.
  - Reset during a fetch drops mem_req immediately; the pending ack is discarded.
- FSM states: OCIOSO, BUSCA, EXECUTA, PARADO.
  - OCIOSO: one cycle after reset deasserts, then BUSCA.
  - BUSCA: mem_req = 1, mem_end = pc.
    - On a rising edge with mem_ack = 1: IR <= mem_dado, counter cleared, go to EXECUTA.
    - An ack in the first BUSCA cycle is valid, giving a minimum fetch latency of 1 cycle.
    - Without an ack the counter increments. When it reaches TIMEOUT_ESPERA with no ack: erro_busca <= 1, go to PARADO.
  - EXECUTA: instr_valida = 1, mem_req = 0. Waits any number of cycles for EscPC, STOP, Ji or Beqz&&Zero. Priority at the edge:
    1. STOP = 1: go to PARADO, pc unchanged. STOP wins over every other input in the same cycle.
    2. EscPC && Ji: pc <= imediato, then BUSCA.
    3. EscPC && Beqz && Zero: pc <= imediato, then BUSCA.
    4. EscPC otherwise (including Beqz with Zero = 0): pc <= pc + 1, wrapping modulo 2^LARGURA_PC, then BUSCA.
    5. No EscPC: remain in EXECUTA with IR held.
  - PARADO: parado = 1, instr_valida = 0, mem_req = 0. Every input is ignored and the state is held until reset.
- mem_ack outside BUSCA is ignored. mem_dado is sampled only on an acknowledged edge.
- instr_valida falls on the same edge on which the PC updates.

Test Plan:
- Reset, then sequential fetch: mem_ack after 2 wait cycles, mem_dado = 8'h0A (opcode 000). Then EscPC = 1 for one cycle → pc goes 0 → 1, mem_end = 1, instr_valida high for exactly the cycles in EXECUTA.
- Jump: IR = 8'b011_10110 with EscPC = 1 and Ji = 1 → pc = 5'b10110 = 22. Next mem_end = 22.
- Branch on ULA compare:
  - Beqz = 1, Zero = 1, imediato = 3 → pc = 3.
  - Repeat with Zero = 0 → pc = old pc + 1.
- STOP: STOP = 1, EscPC = 1 and Ji = 1 all in the same cycle → pc unchanged, parado = 1. Later mem_ack pulses and EscPC pulses have no effect.
- Fetch timeout and wrap-around:
  - mem_ack held low → erro_busca = 1 and parado = 1 after TIMEOUT_ESPERA (15) cycles.
  - Separately, pc = 255 with EscPC → pc = 0.
- Reset mid-fetch: assert reset while mem_req = 1 → mem_req drops the same cycle, without waiting for an edge. After release: one OCIOSO cycle, then BUSCA at pc = PC_INICIAL.
